// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressable data memory with a single outstanding
// request, a fixed access latency, little-endian multi-byte accesses and
// alignment / range fault detection.
module data_mem_unit #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    // Request fields captured on the accept edge.
    logic            we_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   idx_q;
    logic [XLEN-1:0] wdata_q;

    // Zero at simulation start; contents survive reset.
    logic [7:0]      mem_q [DEPTH] = '{default: 8'h00};

    logic            accept;
    logic            access;
    logic [3:0]      req_bytes;
    logic [3:0]      acc_bytes;
    logic            req_misaligned;
    logic            req_out_of_range;
    logic            req_fault;
    logic [XLEN-1:0] raw;
    logic            fill_bit;
    logic [XLEN-1:0] load_val;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign rdata      = rdata_q;
    assign fault      = fault_q;

    assign accept    = req_valid && req_ready;
    assign access    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign req_bytes = 4'd1 << req_size;
    assign acc_bytes = 4'd1 << size_q;

    // Upper address bits only matter here: any set bit pushes the end
    // address past DEPTH. One extra bit keeps addr + size from wrapping.
    assign req_misaligned   = (addr & XLEN'(req_bytes - 4'd1)) != '0;
    assign req_out_of_range = ({1'b0, addr} + (XLEN+1)'(req_bytes)) > (XLEN+1)'(DEPTH);
    assign req_fault        = req_misaligned || req_out_of_range;

    // Gather the addressed bytes little-endian and extend to XLEN.
    always_comb begin
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            if (k < int'(acc_bytes)) begin
                raw[8*k +: 8] = mem_q[idx_q + AW'(k)];
            end
        end
        unique case (size_q)
            2'd0:    fill_bit = raw[7];
            2'd1:    fill_bit = raw[15];
            2'd2:    fill_bit = raw[31];
            default: fill_bit = raw[XLEN-1];
        endcase
        fill_bit = fill_bit & ~uns_q;
        load_val = raw;
        for (int b = 0; b < XLEN; b++) begin
            if (b >= 8 * int'(acc_bytes)) begin
                load_val[b] = fill_bit;
            end
        end
    end

    // Next-state and response-data logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    fault_d = 1'b0;
                    rdata_d = we_q ? '0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                idx_q   <= addr[AW-1:0];
                wdata_q <= wdata;
            end
        end
    end

    // Store path: write exactly the addressed bytes when the wait expires.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; a reset drops the FSM to IDLE
        // at once, so a store still waiting never reaches this write.
        if (access && we_q) begin
            for (int k = 0; k < NB; k++) begin
                if (k < int'(acc_bytes)) begin
                    mem_q[idx_q + AW'(k)] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, giving the byte-addressable storage size (power of two, at least 8).
REQ-003 The block SHALL have parameter LATENCY, default 2, giving the access wait cycles (legal range 1..15).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-010 req_unsigned  input  1  load is zero-extended when 1 and sign-extended when 0.
REQ-011 addr  input  XLEN  byte address.
REQ-012 wdata  input  XLEN  store data; only the low 8<<req_size bits are used.
REQ-013 resp_valid  output  1  single-cycle response strobe.
REQ-014 rdata  output  XLEN  load result.
REQ-015 fault  output  1  response flags a misaligned or out-of-range request; valid with resp_valid.

Function
REQ-016 Storage SHALL be a DEPTH-entry byte array; multi-byte accesses SHALL be little-endian.
REQ-017 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: a request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_we, req_size, req_unsigned, addr and wdata SHALL be latched on that edge.
REQ-019 A request SHALL be faulting if addr mod (1<<req_size) != 0 or if addr + (1<<req_size) > DEPTH.
REQ-020 Faulting accept SHALL go IDLE -> RESP with fault=1 and rdata=0; storage SHALL NOT be modified.
REQ-021 Legal accept SHALL go IDLE -> WAIT and load the wait counter with LATENCY-1.
REQ-022 In WAIT the counter SHALL decrement each cycle; on the edge where it is 0, the access SHALL be performed and the state SHALL go to RESP.
REQ-023 resp_valid SHALL be 1 for exactly the one cycle spent in RESP; RESP -> IDLE unconditionally on the next edge.
REQ-024 Response timing: a legal response SHALL appear LATENCY cycles after the accept edge and a faulting response 1 cycle after it; back-to-back spacing is LATENCY+2 cycles.
REQ-025 A store SHALL write exactly 1<<req_size bytes, leave all other bytes unchanged, and return rdata=0, fault=0.
REQ-026 A load SHALL return the addressed bytes, sign- or zero-extended to XLEN per req_unsigned; for req_size=3, req_unsigned has no effect.
REQ-027 rdata and fault SHALL hold their values from the response until the next response or reset.
REQ-028 req_valid asserted while req_ready=0 SHALL be ignored; it SHALL NOT be queued.
REQ-029 Address bits above log2(DEPTH) participate only in the range check, never in indexing.
REQ-030 Storage SHALL initialise to all zeros at simulation start.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, counter=0, req_ready=1, resp_valid=0, rdata=0 and fault=0.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 A store pending in WAIT when reset asserts SHALL be discarded, with no bytes written.
REQ-034 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Load, size 3, addr 0, after init -> resp_valid 2 cycles after accept, rdata=0, fault=0.
REQ-036 Store, size 3, addr 16, wdata 42, then load, size 3, addr 16 -> rdata=42; overwrite with 99 and reload -> rdata=99.
REQ-037 Store, size 0, addr 8, wdata 0x80, then load byte signed -> 0xFFFF_FFFF_FFFF_FF80; load byte unsigned -> 0x80; load size 3, addr 8 -> 0x80.
REQ-038 Load, size 2, addr 6 -> fault=1, rdata=0, resp 1 cycle after accept; store, size 3, addr 1020 -> fault=1 and bytes 1020..1023 unchanged.
REQ-039 Store issued, then rst_n pulsed low during WAIT -> outputs zero at once, req_ready=1, and a later load of that address returns the old value.
REQ-040 With LATENCY=5, back-to-back loads -> resp_valid spaced 7 cycles, and req_valid held high in non-IDLE cycles gives no extra accept.
